// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// access-size encoding and the byte-lane enable helper.
package mem_pkg;

   localparam int DEPTH_DEFAULT   = 128;
   localparam int LATENCY_DEFAULT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      SIZE_DWORD = 1'b0,
      SIZE_BYTE  = 1'b1
   } access_size_t;

   // Byte accesses touch one lane; doubleword accesses touch all eight.
   function automatic logic [7:0] lane_enable(input access_size_t size, input logic [2:0] lane);
      return (size == SIZE_BYTE) ? (8'(1) << lane) : 8'hFF;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with per-byte write enables and a combinational read
// port sharing the single address.
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [7:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];
   logic [63:0] bit_mask;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign bit_mask[gi*8 +: 8] = {8{be[gi]}};
      end
   endgenerate

   // Contents are never reset so they survive a reset pulse.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Processor MEM-stage data memory: one request in flight, fixed-latency
// response with valid/ready handshakes on both sides.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEFAULT,
   parameter int LATENCY = LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW     = $clog2(DEPTH);
   localparam logic [63:0] LIMIT  = 64'(DEPTH) * 64'd8;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   state_t       state_reg, state_next;
   logic [3:0]   cnt_reg, cnt_next;
   logic [63:0]  rdata_reg, rdata_next;
   logic         err_reg, err_next;

   access_size_t size;
   logic [2:0]   lane;
   logic [AW-1:0] word_idx;
   logic         addr_err;
   logic         accept;
   logic         mem_we;
   logic [7:0]   mem_be;
   logic [63:0]  mem_wdata;
   logic [63:0]  rd_word;
   logic [63:0]  load_data;

   assign size     = access_size_t'(req_byte);
   assign lane     = req_addr[2:0];
   assign word_idx = req_addr[AW+2:3];
   assign addr_err = ((size == SIZE_DWORD) && (lane != 3'd0)) || (req_addr >= LIMIT);

   assign req_ready = (state_reg == ST_IDLE) && reset;
   assign accept    = req_valid && req_ready;

   // Stores commit on the acceptance edge; errored stores never reach the array.
   assign mem_we    = accept && req_we && !addr_err;
   assign mem_be    = lane_enable(size, lane);
   assign mem_wdata = (size == SIZE_BYTE) ? {8{req_wdata[7:0]}} : req_wdata;

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (word_idx),
      .wdata (mem_wdata),
      .rdata (rd_word)
   );

   always_comb begin
      load_data = 64'd0;
      if (!addr_err && !req_we) begin
         if (size == SIZE_BYTE) begin
            load_data = {56'd0, rd_word[{lane, 3'b000} +: 8]};
         end else begin
            load_data = rd_word;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               rdata_next = load_data;
               err_next   = addr_err;
               if (LATENCY == 1) begin
                  state_next = ST_RESP;
                  cnt_next   = 4'd0;
               end else begin
                  state_next = ST_BUSY;
                  cnt_next   = LAT_M1;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_reg <= 4'd1) begin
               cnt_next   = 4'd0;
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
               rdata_next = 64'd0;
               err_next   = 1'b0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
            rdata_next = 64'd0;
            err_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         rdata_reg <= 64'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
      end
   end

   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_err   = rsp_valid && err_reg;
   assign rsp_rdata = rsp_valid ? rdata_reg : 64'd0;

endmodule
